// File: rtl/frame_packer.sv
// frame_packer: packs 8-bit pixels into 128-bit frame RAM words.
// `define FRAME_PACKER_CONTINUOUS_EN to roll into the next frame without sof.
`timescale 1ns/1ps
module frame_packer #(
    parameter int DEPTH = 13,
    parameter int WIDTH = 128,
    parameter int PIX_W = 8,
    parameter int WORDS = 4800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             we,
    output logic [DEPTH-1:0] a,
    output logic [WIDTH-1:0] di,
    output logic             busy,
    output logic             frame_done
);

    localparam int LANES = WIDTH / PIX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state;
    logic [3:0]       lane;
    logic [DEPTH-1:0] waddr;
    logic [WIDTH-1:0] asm_q;

    logic [3:0]       lane_in;
    logic             take;
    logic [WIDTH-1:0] word_nx;

    // sof restarts the word, so a coincident pixel always lands in lane 0
    assign lane_in = sof ? 4'd0 : lane;
    assign take    = pix_valid && (sof || state == FILL);

    always_comb begin
        word_nx = asm_q;
        word_nx[lane_in*PIX_W +: PIX_W] = pix_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lane       <= '0;
            waddr      <= '0;
            asm_q      <= '0;
            we         <= 1'b0;
            a          <= '0;
            di         <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;

            if (sof) begin
                state <= FILL;
                busy  <= 1'b1;
                lane  <= '0;
                waddr <= '0;
            end else if (frame_done) begin
`ifdef FRAME_PACKER_CONTINUOUS_EN
                busy <= 1'b1;
`else
                busy <= 1'b0;
`endif
            end

            if (take) begin
                asm_q <= word_nx;
                if (lane_in == 4'(LANES - 1)) begin
                    we   <= 1'b1;
                    a    <= waddr;
                    di   <= word_nx;
                    lane <= '0;
                    if (waddr == DEPTH'(WORDS - 1)) begin
                        frame_done <= 1'b1;
                        waddr      <= '0;
`ifdef FRAME_PACKER_CONTINUOUS_EN
                        state <= FILL;
`else
                        state <= IDLE;
`endif
                    end else begin
                        waddr <= waddr + DEPTH'(1);
                    end
                end else begin
                    lane <= lane_in + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: random pixel stream against a pixel-queue reference model.
`timescale 1ns/1ps
module tb_frame_packer;

`ifdef FRAME_PACKER_CONTINUOUS_EN
    localparam int NW   = 600;
    localparam bit CONT = 1'b1;
`else
    localparam int NW   = 4800;
    localparam bit CONT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sof = 1'b0;
    logic         pix_valid = 1'b0;
    logic [7:0]   pix_data = '0;
    logic         we;
    logic [12:0]  a;
    logic [127:0] di;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    frame_packer #(
        .DEPTH(13), .WIDTH(128), .PIX_W(8), .WORDS(NW)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .we(we), .a(a), .di(di),
        .busy(busy), .frame_done(frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_we  = 0;
    int n_fd  = 0;

    // reference model: frame active flag, pixels of the open word, word index
    bit           m_active;
    byte unsigned pq[$];
    int           widx;
    logic         m_we, m_fd, m_busy;
    logic [12:0]  m_a;
    logic [127:0] m_di;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        pq.delete();
        widx   = 0;
        m_we   = 1'b0;
        m_fd   = 1'b0;
        m_busy = 1'b0;
        m_a    = '0;
        m_di   = '0;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_a"}, a, 0);
        check({tag, "_di"}, di, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fd"}, frame_done, 0);
    endtask

    task automatic step(bit s, bit v, logic [7:0] d);
        logic [127:0] w;
        sof = s;
        pix_valid = v;
        pix_data = d;
        @(posedge clk);
        if (s) m_busy = 1'b1;
        else if (m_fd && !CONT) m_busy = 1'b0;
        m_we = 1'b0;
        m_fd = 1'b0;
        if (s) begin
            m_active = 1'b1;
            pq.delete();
            widx = 0;
        end
        if (m_active && v) begin
            pq.push_back(d);
            if (pq.size() == 16) begin
                w = '0;
                for (int i = 0; i < 16; i++)
                    w = w | (128'(pq[i]) << (8 * i));
                m_we = 1'b1;
                m_a  = 13'(widx);
                m_di = w;
                m_fd = (widx == NW - 1);
                pq.delete();
                if (m_fd) begin
                    widx = 0;
                    if (!CONT) m_active = 1'b0;
                end else begin
                    widx++;
                end
            end
        end
        #1;
        check("we", we, m_we);
        check("a", a, m_a);
        check("di", di, m_di);
        check("frame_done", frame_done, m_fd);
        check("busy", busy, m_busy);
        n_we += int'(we);
        n_fd += int'(frame_done);
    endtask

    initial begin
        int lim;
        int cyc;
        logic [127:0] aa_word;
        logic [127:0] ramp;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // pixels without sof stay ignored
        repeat (40) step(1'b0, 1'b1, 8'($urandom));

        // one ramp word
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i));
        ramp = 128'h0F0E0D0C0B0A09080706050403020100;
        check("ramp_we", we, 1);
        check("ramp_a", a, 0);
        check("ramp_di", di, ramp);

        // restart partway through word 3
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 55; i++) step(1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hAA);
        aa_word = {16{8'hAA}};
        check("restart_we", we, 1);
        check("restart_a", a, 0);
        check("restart_di", di, aa_word);

        // random sof, gaps and sof with pixel
        for (int i = 0; i < 400; i++)
            step($urandom_range(99, 0) == 0, $urandom_range(3, 0) != 0,
                 8'($urandom));

        // asynchronous reset between edges, mid-word
        step(1'b1, 1'b1, 8'($urandom));
        repeat (5) step(1'b0, 1'b1, 8'($urandom));
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        #2 rst = 1'b0;
        step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'($urandom));
        check("post_rst_we", we, 1);
        check("post_rst_a", a, 0);

        // full frame(s) with random pixel gaps
        n_we = 0;
        n_fd = 0;
        lim = NW * 16 * 2 * (CONT ? 2 : 1);
        cyc = 0;
        step(1'b1, 1'b0, 8'h00);
        while (n_fd < (CONT ? 2 : 1) && cyc < lim) begin
            step(1'b0, $urandom_range(15, 0) != 0, 8'($urandom));
            cyc++;
        end
        check("frame_count", n_fd, CONT ? 2 : 1);
        check("write_count", n_we, NW * (CONT ? 2 : 1));
        repeat (20) step(1'b0, 1'b1, 8'($urandom));
        check("busy_after", busy, CONT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
